// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// wb_regfile : write-back register file, 2 bypassed read ports, debug dump
// Rev 1.0
// ============================================================================
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              dbg_req,
    output logic              dbg_busy,
    output logic              dbg_valid,
    input  logic              dbg_ready,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              dbg_last,
    output logic [31:0]       wr_count
);

    localparam logic [0:0]        IDLE      = 1'b0;
    localparam logic [0:0]        SEND      = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

    logic [DATA_W-1:0] regs [NREGS];
    logic [0:0]        state;
    logic              commit;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] next_data;

    assign commit    = !rst && wb_we && (wb_waddr != '0);
    assign next_addr = dbg_addr + 1'b1;

    // Register file; entry 0 is never written so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (commit) begin
            regs[wb_waddr] <= wb_wdata;
            wr_count       <= wr_count + 32'd1;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (!rst && re1 && (raddr1 != '0)) begin
            if (wb_we && (wb_waddr == raddr1)) begin
                rdata1 = wb_wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!rst && re2 && (raddr2 != '0)) begin
            if (wb_we && (wb_waddr == raddr2)) begin
                rdata2 = wb_wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
        end
    end

    // Next beat sees a write landing on the same edge it is loaded.
    always_comb begin
        if (commit && (wb_waddr == next_addr)) begin
            next_data = wb_wdata;
        end else begin
            next_data = regs[next_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dbg_addr <= '0;
            dbg_data <= '0;
            dbg_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dbg_req) begin
                        state    <= SEND;
                        dbg_addr <= '0;
                        dbg_data <= '0;
                        dbg_last <= (NREGS == 1);
                    end
                end
                SEND: begin
                    if (dbg_ready) begin
                        if (dbg_addr == LAST_ADDR) begin
                            state    <= IDLE;
                            dbg_last <= 1'b0;
                        end else begin
                            dbg_addr <= next_addr;
                            dbg_data <= next_data;
                            dbg_last <= (next_addr == LAST_ADDR);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_valid = (state == SEND);
    assign dbg_busy  = (state == SEND);

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// tb_wb_regfile : directed + random checks of wb_regfile against an array model
// Rev 1.0
// ============================================================================
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        dbg_req, dbg_busy, dbg_valid, dbg_ready, dbg_last;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] wr_count;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] model [32];
    logic [31:0] model_count;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .dbg_req(dbg_req), .dbg_busy(dbg_busy), .dbg_valid(dbg_valid),
        .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .dbg_last(dbg_last), .wr_count(wr_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic re, input logic [4:0] a);
        if (rst || !re || a == 5'd0) return 32'd0;
        if (wb_we && wb_waddr == a) return wb_wdata;
        return model[a];
    endfunction

    // Apply the current inputs to the model, then advance one clock edge.
    task automatic step();
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
            model_count = 32'd0;
        end else if (wb_we && wb_waddr != 5'd0) begin
            model[wb_waddr] = wb_wdata;
            model_count = model_count + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
        step();
        wb_we = 1'b0;
    endtask

    task automatic check_reads(input string tag);
        #1;
        check({tag, "_rd1"}, rdata1, exp_read(re1, raddr1));
        check({tag, "_rd2"}, rdata2, exp_read(re2, raddr2));
    endtask

    // One dump; toggle selects 1/0 backpressure, abort_at asserts rst on that beat.
    task automatic dump(input bit toggle, input int abort_at);
        int          b;
        int          cyc;
        bit          accepted;
        logic [31:0] exp_beat;
        dbg_req = 1'b1;
        #1;
        check("dump_idle_valid", {31'd0, dbg_valid}, 32'd0);
        step();
        dbg_req  = 1'b0;
        b        = 0;
        cyc      = 0;
        exp_beat = 32'd0;
        while (b < 32 && cyc < 400) begin
            dbg_ready = toggle ? cyc[0] : 1'b1;
            wb_we     = 1'b0;
            dbg_req   = (b == 5);
            if (b == 3 && dbg_ready) begin
                wb_we = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'h99;
            end
            if (b == 8 && !dbg_ready) begin
                wb_we = 1'b1; wb_waddr = 5'd8; wb_wdata = 32'h5555;
            end
            if (b == abort_at) rst = 1'b1;
            #1;
            check("dump_valid", {31'd0, dbg_valid}, 32'd1);
            check("dump_busy", {31'd0, dbg_busy}, 32'd1);
            check("dump_addr", {27'd0, dbg_addr}, b);
            check("dump_data", dbg_data, exp_beat);
            check("dump_last", {31'd0, dbg_last}, {31'd0, b == 31});
            accepted = dbg_ready && !rst;
            step();
            if (rst) begin
                rst = 1'b0; wb_we = 1'b0; dbg_req = 1'b0;
                check("abort_valid", {31'd0, dbg_valid}, 32'd0);
                check("abort_busy", {31'd0, dbg_busy}, 32'd0);
                return;
            end
            if (accepted) begin
                b++;
                if (b < 32) exp_beat = model[b];
            end
            cyc++;
        end
        wb_we = 1'b0; dbg_req = 1'b0; dbg_ready = 1'b0;
        check("dump_complete_beats", b, 32);
        #1;
        check("dump_end_valid", {31'd0, dbg_valid}, 32'd0);
        check("dump_end_busy", {31'd0, dbg_busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
        dbg_req = 1'b0; dbg_ready = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        model_count = 32'd0;
        step(); step();
        check_reads("rst_held");
        check("rst_count", wr_count, 32'd0);
        check("rst_valid", {31'd0, dbg_valid}, 32'd0);
        rst = 1'b0;

        write(5'd5, 32'h1234);
        check("pre_rst_count", wr_count, 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        raddr1 = 5'd5;
        check_reads("after_rst");
        check("after_rst_rd_x5", rdata1, 32'd0);
        check("after_rst_count", wr_count, 32'd0);
        check("after_rst_valid", {31'd0, dbg_valid}, 32'd0);

        write(5'd3, 32'hDEADBEEF);
        raddr1 = 5'd3;
        #1;
        check("wr_rd_x3", rdata1, 32'hDEADBEEF);
        check("wr_rd_count", wr_count, 32'd1);

        wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFFFFFFFF; raddr2 = 5'd0;
        #1;
        check("x0_bypass", rdata2, 32'd0);
        step(); wb_we = 1'b0;
        check("x0_read", rdata2, 32'd0);
        check("x0_count", wr_count, 32'd1);

        wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'hA5A5A5A5;
        raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        check("bypass_rd1", rdata1, 32'hA5A5A5A5);
        check("bypass_rd2", rdata2, 32'hA5A5A5A5);
        step(); wb_we = 1'b0;
        check("bypass_count", wr_count, 32'd2);

        for (int k = 0; k < 200; k++) begin
            wb_we    = 1'($urandom_range(0, 1));
            wb_waddr = 5'($urandom_range(0, 31));
            wb_wdata = $urandom;
            re1      = ($urandom_range(0, 3) != 0);
            re2      = ($urandom_range(0, 3) != 0);
            raddr1   = ($urandom_range(0, 3) == 0) ? wb_waddr : 5'($urandom_range(0, 31));
            raddr2   = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
            check_reads("rand");
            step();
            check("rand_count", wr_count, model_count);
        end
        wb_we = 1'b0;

        for (int i = 1; i < 32; i++) write(5'(i), 32'(i * 32'h10));
        dump(1'b1, -1);
        check("dump_count", wr_count, model_count);
        dump(1'b0, 10);
        check("abort_regs_clear_count", wr_count, 32'd0);
        for (int i = 0; i < 12; i++) write(5'($urandom_range(1, 31)), $urandom);
        dump(1'b0, -1);
        re1 = 1'b1; raddr1 = 5'd4;
        check_reads("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
